uart_frame_decoder: RTL and testbench
=====================================

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum payload bytes per frame (1..15).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 100000, maximum clk cycles allowed between bytes inside a frame.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_done  input  1  one-cycle pulse from the UART receiver; rx_byte is valid in that cycle.
REQ-007 SHALL have port rx_byte  input  8  received byte.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse when a good frame completes.
REQ-009 SHALL have port frame_cmd  output  8  command byte of the last good frame.
REQ-010 SHALL have port frame_len  output  4  payload length of the last good frame.
REQ-011 SHALL have port frame_data  output  8*MAX_LEN  payload of the last good frame; byte i at bits [8i+7:8i].
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse when a frame is aborted.
REQ-013 SHALL have port err_code  output  2  reason for the last abort: 01 length, 10 checksum, 11 timeout.

Function
REQ-014 Frame format SHALL be SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK; CHK = XOR of CMD, LEN and all payload bytes.
REQ-015 FSM states SHALL be HUNT, CMD, LEN, DATA, CHK; exactly one byte is consumed per rx_done pulse; no state change without rx_done except on timeout.
REQ-016 HUNT: rx_byte==SYNC_BYTE -> CMD; any other byte is discarded silently with no error.
REQ-017 CMD: store the byte, seed the running checksum with it -> LEN.
REQ-018 LEN: byte > MAX_LEN -> frame_err with err_code=01, -> HUNT; byte==0 -> CHK; otherwise -> DATA.
REQ-019 DATA: write the byte to working-buffer slot index, XOR it into the checksum, and increment index; after LEN bytes -> CHK.
REQ-020 CHK: rx_byte==checksum -> frame_valid; mismatch -> frame_err with err_code=10; both paths -> HUNT.
REQ-021 The working buffer SHALL be cleared on entry to CMD, so that payload slots at index >= LEN are zero.
REQ-022 On frame_valid, frame_cmd, frame_len and frame_data SHALL load from the working registers in the same edge.
REQ-023 frame_cmd, frame_len and frame_data SHALL then hold until the next frame_valid; errors SHALL NOT modify them.
REQ-024 frame_valid and frame_err SHALL assert on the clk edge following the rx_done cycle of the deciding byte (1-cycle latency).
REQ-025 frame_valid and frame_err SHALL each last exactly one cycle and SHALL never be high together.
REQ-026 err_code SHALL hold its value until the next frame_err.
REQ-027 Inter-byte counter: reset to 0 on every rx_done; otherwise increment while the FSM is not in HUNT; held at 0 in HUNT.
REQ-028 When the counter reaches TIMEOUT_CLKS-1 outside HUNT -> frame_err with err_code=11, -> HUNT.
REQ-029 If rx_done coincides with timeout expiry, the byte SHALL win: it is processed normally and no timeout is raised.
REQ-030 A SYNC_BYTE value received in states CMD..CHK SHALL be treated as ordinary data; there is no resynchronisation mid-frame.
REQ-031 The checksum register SHALL be 8 bits and the index register ceil(log2(MAX_LEN+1)) bits; no overflow is possible given REQ-018.

Reset
REQ-032 While reset is high, the FSM SHALL be in HUNT and the counter, index, checksum and working buffer SHALL be 0.
REQ-033 While reset is high, frame_valid, frame_err, err_code, frame_cmd, frame_len and frame_data SHALL all be 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame without any frame_err pulse; after release, decoding restarts in HUNT.

Verification (MAX_LEN=4, TIMEOUT_CLKS=64)
REQ-035 Bytes A5 10 02 AA 55 ED -> one frame_valid; frame_cmd=10, frame_len=2, frame_data=32'h0000_55AA; frame_err stays 0.
REQ-036 Bytes 00 FF A5 20 00 20 -> leading 00 FF ignored; frame_valid; frame_cmd=20, frame_len=0, frame_data=0.
REQ-037 Bytes A5 10 05 -> frame_err with err_code=01 one cycle after the 05 rx_done; then A5 30 00 30 -> frame_valid.
REQ-038 Bytes A5 10 01 77 00 -> frame_err with err_code=10; frame_* outputs keep the previous good frame's values.
REQ-039 Bytes A5 10 then no rx_done for 64 cycles -> frame_err with err_code=11; a byte landing exactly on the expiry cycle -> no error.
REQ-040 Reset pulsed after A5 10 02 AA -> no pulses and all outputs 0; then a full good frame -> frame_valid.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// Byte-stream frame decoder: SYNC, CMD, LEN, payload, XOR checksum.
// Good frames are latched onto the frame_* outputs; aborted frames pulse frame_err with a reason.
module uart_frame_decoder #(
  parameter int unsigned MAX_LEN      = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_done,
  input  logic [7:0]             rx_byte,
  output logic                   frame_valid,
  output logic [7:0]             frame_cmd,
  output logic [3:0]             frame_len,
  output logic [8*MAX_LEN-1:0]   frame_data,
  output logic                   frame_err,
  output logic [1:0]             err_code
);

  localparam int unsigned IdxW = $clog2(MAX_LEN + 1);
  localparam int unsigned CntW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

  typedef enum logic [2:0] {StHunt, StCmd, StLen, StData, StChk} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [7:0]           chk_q, chk_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [3:0]           len_q, len_d;
  logic [8*MAX_LEN-1:0] buf_q, buf_d;
  logic                 valid_d, err_d;
  logic [1:0]           code_d;
  logic                 frame_valid_q, frame_err_q;
  logic [1:0]           err_code_q;
  logic [7:0]           frame_cmd_q;
  logic [3:0]           frame_len_q;
  logic [8*MAX_LEN-1:0] frame_data_q;
  logic [IdxW-1:0]      idx_nxt;

  assign idx_nxt = idx_q + 1'b1;

  // Next-state: byte-driven frame parsing plus inter-byte timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    buf_d   = buf_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = err_code_q;

    if (rx_done || state_q == StHunt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (rx_done) begin
      // A received byte always wins over a coincident timeout.
      unique case (state_q)
        StHunt: begin
          if (rx_byte == SYNC_BYTE) begin
            state_d = StCmd;
            buf_d   = '0;
            idx_d   = '0;
          end
        end
        StCmd: begin
          cmd_d   = rx_byte;
          chk_d   = rx_byte;
          state_d = StLen;
        end
        StLen: begin
          idx_d = '0;
          if (rx_byte > 8'(MAX_LEN)) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = StHunt;
          end else begin
            len_d   = rx_byte[3:0];
            chk_d   = chk_q ^ rx_byte;
            state_d = (rx_byte == 8'd0) ? StChk : StData;
          end
        end
        StData: begin
          buf_d[8*int'(idx_q) +: 8] = rx_byte;
          chk_d = chk_q ^ rx_byte;
          idx_d = idx_nxt;
          if (4'(idx_nxt) == len_q) begin
            state_d = StChk;
          end
        end
        StChk: begin
          if (rx_byte == chk_q) begin
            valid_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b10;
          end
          state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end else if (state_q != StHunt && cnt_q == CntW'(TIMEOUT_CLKS - 1)) begin
      err_d   = 1'b1;
      code_d  = 2'b11;
      state_d = StHunt;
      cnt_d   = '0;
    end
  end

  // Working registers of the frame currently being parsed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHunt;
      cnt_q   <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
      cmd_q   <= '0;
      len_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
    end
  end

  // Output registers: pulses for one cycle, frame fields only update on a good frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
      frame_cmd_q   <= '0;
      frame_len_q   <= '0;
      frame_data_q  <= '0;
    end else begin
      frame_valid_q <= valid_d;
      frame_err_q   <= err_d;
      err_code_q    <= code_d;
      if (valid_d) begin
        frame_cmd_q  <= cmd_q;
        frame_len_q  <= len_q;
        frame_data_q <= buf_q;
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign frame_cmd   = frame_cmd_q;
  assign frame_len   = frame_len_q;
  assign frame_data  = frame_data_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder (MAX_LEN=4, TIMEOUT_CLKS=64).
module tb_uart_frame_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_done;
  logic [7:0]  rx_byte;
  logic        frame_valid;
  logic [7:0]  frame_cmd;
  logic [3:0]  frame_len;
  logic [31:0] frame_data;
  logic        frame_err;
  logic [1:0]  err_code;

  uart_frame_decoder #(
    .MAX_LEN      (4),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done     (rx_done),
    .rx_byte     (rx_byte),
    .frame_valid (frame_valid),
    .frame_cmd   (frame_cmd),
    .frame_len   (frame_len),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cyc = 0;

  // Bench model of the held outputs.
  logic [7:0]  good_cmd  = '0;
  logic [3:0]  good_len  = '0;
  logic [31:0] good_data = '0;
  logic [1:0]  last_code = '0;
  logic [7:0]  e_cmd;
  logic [3:0]  e_len;
  logic [31:0] e_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops one expectation per output pulse and compares timing and fields.
  always @(negedge clk) begin
    if (!reset && (frame_valid || frame_err)) begin
      exp_t e;
      if (frame_valid && frame_err) begin
        check("valid_and_err_together", 32'(frame_err), 32'd0);
      end else if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
        check("pulse_cycle", cyc, e.due);
        check("err_code", 32'(err_code), 32'(e.code));
        check("frame_cmd", 32'(frame_cmd), 32'(e.cmd));
        check("frame_len", 32'(frame_len), 32'(e.len));
        check("frame_data", frame_data, e.data);
      end
    end
  end

  // kind: 0 plain byte, 1 completes a good frame (e_* fields), 2 aborts with code.
  task automatic send_at(input logic [7:0] b, input int tgt, input int kind, input logic [1:0] code);
    exp_t e;
    do begin
      @(posedge clk);
      #1;
    end while (cyc < tgt);
    if (kind == 1) begin
      good_cmd = e_cmd; good_len = e_len; good_data = e_data;
      e = '{is_err: 1'b0, code: last_code, cmd: good_cmd, len: good_len, data: good_data,
            due: cyc + 1};
      sb.push_back(e);
    end else if (kind == 2) begin
      last_code = code;
      e = '{is_err: 1'b1, code: code, cmd: good_cmd, len: good_len, data: good_data,
            due: cyc + 1};
      sb.push_back(e);
    end
    rx_byte  = b;
    rx_done  = 1'b1;
    last_cyc = cyc;
    @(posedge clk);
    #1;
    rx_done  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_at(b, cyc + 1, 0, 2'b00);
  endtask

  task automatic send_good(input logic [7:0] b, input logic [7:0] c, input logic [3:0] l,
                           input logic [31:0] d);
    e_cmd = c; e_len = l; e_data = d;
    send_at(b, cyc + 1, 1, 2'b00);
  endtask

  task automatic send_bad(input logic [7:0] b, input logic [1:0] code);
    send_at(b, cyc + 1, 2, code);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(frame_valid), 32'd0);
    check({tag, "_err"},   32'(frame_err),   32'd0);
    check({tag, "_code"},  32'(err_code),    32'd0);
    check({tag, "_cmd"},   32'(frame_cmd),   32'd0);
    check({tag, "_len"},   32'(frame_len),   32'd0);
    check({tag, "_data"},  frame_data,       32'd0);
  endtask

  initial begin
    exp_t e;
    int   n;
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_byte = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Two-byte payload.
    send(8'hA5); send(8'h10); send(8'h02); send(8'hAA); send(8'h55);
    send_good(8'hED, 8'h10, 4'd2, 32'h0000_55AA);

    // Leading noise ignored, empty payload.
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h20); send(8'h00);
    send_good(8'h20, 8'h20, 4'd0, 32'h0);

    // Length too large, then a good frame.
    send(8'hA5); send(8'h10);
    send_bad(8'h05, 2'b01);
    send(8'hA5); send(8'h30); send(8'h00);
    send_good(8'h30, 8'h30, 4'd0, 32'h0);

    // Checksum mismatch keeps previous frame fields.
    send(8'hA5); send(8'h10); send(8'h01); send(8'h77);
    send_bad(8'h00, 2'b10);

    // Timeout: 64 idle cycles after the CMD byte.
    send(8'hA5); send(8'h10);
    n = last_cyc;
    e = '{is_err: 1'b1, code: 2'b11, cmd: good_cmd, len: good_len, data: good_data, due: n + 65};
    sb.push_back(e);
    last_code = 2'b11;
    repeat (75) @(posedge clk);
    #1;

    // Byte landing on the expiry cycle is processed; no timeout.
    send(8'hA5); send(8'h10);
    n = last_cyc;
    send_at(8'h01, n + 64, 0, 2'b00);
    send(8'h77);
    send_good(8'h66, 8'h10, 4'd1, 32'h0000_0077);

    // Full-length payload, then a short one to check the buffer is cleared.
    send(8'hA5); send(8'h42); send(8'h04);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send_good(8'h02, 8'h42, 4'd4, 32'h4433_2211);
    send(8'hA5); send(8'h05); send(8'h01); send(8'h99);
    send_good(8'h9D, 8'h05, 4'd1, 32'h0000_0099);

    // SYNC value inside a frame is plain data.
    send(8'hA5); send(8'h01); send(8'h01); send(8'hA5);
    send_good(8'hA5, 8'h01, 4'd1, 32'h0000_00A5);

    // Reset mid-frame.
    send(8'hA5); send(8'h10); send(8'h02); send(8'hAA);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("midreset_hold");
    good_cmd = '0; good_len = '0; good_data = '0; last_code = '0;
    reset = 1'b0;
    send(8'hA5); send(8'h10); send(8'h02); send(8'hAA); send(8'h55);
    send_good(8'hED, 8'h10, 4'd2, 32'h0000_55AA);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
